// File: rtl/down_timer.sv
// down_timer: loadable down-counter with optional auto-reload.
// A load of N starts a count in RUN; each enabled edge decrements out.
// Reaching the terminal count produces a one-cycle registered tc pulse and
// either parks in DONE with out=0 or restarts from the stored reload value.
// A load of zero goes straight to DONE with a tc pulse.
module down_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] reload_reg;
  logic             tc_reg;

  // True on the enabled edge where the count is about to expire.
  logic             at_terminal;
  assign at_terminal = (count_reg == WIDTH'(1));

  // State, count, reload value and tc pulse; priority is clr, load, count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      reload_reg <= '0;
      tc_reg     <= 1'b0;
    end else if (clr) begin
      // Clear keeps the reload value; only the running count is dropped.
      state_reg <= IDLE;
      count_reg <= '0;
      tc_reg    <= 1'b0;
    end else if (load) begin
      count_reg  <= load_val;
      reload_reg <= load_val;
      if (load_val != '0) begin
        state_reg <= RUN;
        tc_reg    <= 1'b0;
      end else begin
        // A zero load is an immediate terminal event.
        state_reg <= DONE;
        tc_reg    <= 1'b1;
      end
    end else if ((state_reg == RUN) && en) begin
      if (at_terminal) begin
        tc_reg <= 1'b1;
        if (auto_reload) begin
          // Jump straight to the reload value so out never shows zero.
          count_reg <= reload_reg;
        end else begin
          count_reg <= '0;
          state_reg <= DONE;
        end
      end else begin
        // In RUN the count is always >= 1, so this cannot wrap.
        count_reg <= count_reg - WIDTH'(1);
        tc_reg    <= 1'b0;
      end
    end else begin
      // Paused in RUN, or sitting in IDLE/DONE: hold everything but tc.
      tc_reg <= 1'b0;
    end
  end

  // Status flags decoded straight from the state register.
  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign out  = count_reg;
  assign tc   = tc_reg;

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed plus randomized stimulus against a behavioural
// model; expected responses are queued by the driver and popped by a monitor.
module tb_down_timer;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             tc;

  down_timer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
    .en         (en),
    .auto_reload(auto_reload),
    .out        (out),
    .busy       (busy),
    .done       (done),
    .tc         (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned out;
    bit          busy;
    bit          done;
    bit          tc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_txn    = 0;

  // Behavioural model: a mode label, the visible count, the remembered
  // start value and whether the previous edge was a terminal event.
  string       m_mode   = "idle";
  int unsigned m_count  = 0;
  int unsigned m_start  = 0;
  bit          m_pulse  = 0;

  task automatic model_edge(input bit r, input bit c, input bit ld,
                            input int unsigned lv, input bit e, input bit ar);
    bit fired;
    fired = 0;
    if (!r) begin
      m_mode = "idle"; m_count = 0; m_start = 0;
    end else if (c) begin
      m_mode = "idle"; m_count = 0;
    end else if (ld) begin
      m_start = lv;
      m_count = lv;
      if (lv == 0) begin m_mode = "done"; fired = 1; end
      else m_mode = "run";
    end else if (m_mode == "run" && e) begin
      // Counting: N enabled edges after a load of N reach the terminal event.
      if (m_count >= 2) m_count = m_count - 1;
      else begin
        fired = 1;
        if (ar) m_count = m_start;
        else begin m_count = 0; m_mode = "done"; end
      end
    end
    m_pulse = fired;
  endtask

  // One clock of stimulus: drive on the falling edge, queue the expectation
  // for the following rising edge, and check async reset immediately.
  task automatic step(input bit r, input bit c, input bit ld,
                      input logic [WIDTH-1:0] lv, input bit e, input bit ar);
    exp_t x;
    @(negedge clk);
    rst = r; clr = c; load = ld; load_val = lv; en = e; auto_reload = ar;
    model_edge(r, c, ld, int'(lv), e, ar);
    x.out = m_count; x.busy = (m_mode == "run");
    x.done = (m_mode == "done"); x.tc = m_pulse;
    exp_q.push_back(x);
    if (!r) begin
      #1;
      n_checks++;
      if (out == '0 && busy == 1'b0 && done == 1'b0 && tc == 1'b0) n_pass++;
      else $display("FAIL async_reset: out=%0d busy=%0b done=%0b tc=%0b, required out=0 busy=0 done=0 tc=0",
                    out, busy, done, tc);
    end
  endtask

  // Monitor: one comparison per clock against the oldest queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_txn++;
        n_checks++;
        if (int'(out) == int'(x.out) && busy == x.busy && done == x.done && tc == x.tc) begin
          n_pass++;
          $display("txn %0d: out=%0d busy=%0b done=%0b tc=%0b ok", n_txn, out, busy, done, tc);
        end else begin
          $display("FAIL txn %0d: got out=%0d busy=%0b done=%0b tc=%0b, required out=%0d busy=%0b done=%0b tc=%0b",
                   n_txn, out, busy, done, tc, x.out, x.busy, x.done, x.tc);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;

    // Reset, then idle with en high: nothing should move.
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 16'd7, 1, 1);          // inputs ignored during reset
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);

    // Basic count: 5,4,3,2,1,0 then DONE.
    step(1, 0, 1, 16'd5, 1, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 1, 0);

    // Pause pattern.
    step(1, 0, 1, 16'd4, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 0);

    // Auto-reload: 9 enabled edges, three tc pulses.
    step(1, 0, 1, 16'd3, 0, 1);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 1, 1);
    step(1, 1, 0, 0, 0, 0);

    // Zero load: straight to DONE with a single tc.
    step(1, 0, 1, 16'd0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);

    // Load wins over a terminal event.
    step(1, 0, 1, 16'd5, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 0);
    step(1, 0, 1, 16'd9, 1, 0);
    step(1, 0, 0, 0, 1, 0);

    // Clear beats load; reload of 1 gives an immediate terminal.
    step(1, 1, 1, 16'd6, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 1, 16'd1, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);

    // Async reset mid-count, then en after release must not start anything.
    step(1, 0, 1, 16'd10, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit r, c, ld, e, ar;
      logic [WIDTH-1:0] lv;
      r  = ($urandom_range(0, 99) >= 1);
      c  = ($urandom_range(0, 99) < 3);
      ld = ($urandom_range(0, 99) < 10);
      e  = ($urandom_range(0, 99) < 70);
      ar = ($urandom_range(0, 99) < 30);
      lv = ($urandom_range(0, 99) < 15) ? 16'd0 : 16'($urandom_range(1, 12));
      step(r, c, ld, lv, e, ar);
    end
    step(1, 0, 0, 0, 0, 0);

    // Every queued expectation must have been consumed.
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
